// File: rtl/maxpool_relu_nch.sv
// 2x2 / stride-2 max pooling with optional ReLU over NUM_CH parallel signed channels.
//
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-high reset
//   relu_en       - clamp negative pooled results to zero (sampled on window-completing beats)
//   frame_restart - synchronous return to pixel (0,0); drops the same-cycle input beat
//   valid_in      - data_in carries a pixel this cycle
//   data_in       - NUM_CH packed samples, channel k at [k*DATA_BIT +: DATA_BIT]
//   valid_out     - data_out holds a new pooled pixel this cycle
//   data_out      - NUM_CH packed pooled samples, same packing as data_in
//   frame_done    - one-cycle pulse with the last pooled pixel of a frame
module maxpool_relu_nch #(
    parameter int unsigned DATA_BIT  = 12,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned IN_WIDTH  = 24,
    parameter int unsigned IN_HEIGHT = 24,
    parameter int unsigned COL_BIT   = 5,
    parameter int unsigned ROW_BIT   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         relu_en,
    input  logic                         frame_restart,
    input  logic                         valid_in,
    input  logic [NUM_CH*DATA_BIT-1:0]   data_in,
    output logic                         valid_out,
    output logic [NUM_CH*DATA_BIT-1:0]   data_out,
    output logic                         frame_done
);

    localparam int unsigned LB_DEPTH = IN_WIDTH / 2;
    localparam int unsigned LB_BIT   = COL_BIT - 1;

    logic [COL_BIT-1:0]          col_q;
    logic [ROW_BIT-1:0]          row_q;
    logic signed [DATA_BIT-1:0]  h_q  [NUM_CH];
    logic signed [DATA_BIT-1:0]  lb_q [NUM_CH][LB_DEPTH];

    logic                        valid_out_q;
    logic                        frame_done_q;
    logic [NUM_CH*DATA_BIT-1:0]  data_out_q;

    logic signed [DATA_BIT-1:0]  sample [NUM_CH];
    logic signed [DATA_BIT-1:0]  hmax   [NUM_CH];
    logic signed [DATA_BIT-1:0]  pooled [NUM_CH];
    logic [NUM_CH*DATA_BIT-1:0]  pooled_flat;

    logic              col_last;
    logic              row_last;
    logic              beat;
    logic              win_done;
    logic [LB_BIT-1:0] lb_idx;

    assign col_last = (col_q == COL_BIT'(IN_WIDTH - 1));
    assign row_last = (row_q == ROW_BIT'(IN_HEIGHT - 1));
    // Restart wins over valid_in: the coincident beat is discarded.
    assign beat     = valid_in & ~frame_restart;
    assign win_done = beat & col_q[0] & row_q[0];
    assign lb_idx   = col_q[COL_BIT-1:1];

    // Signed compare only; no arithmetic, so the most-negative code is safe.
    always_comb begin
        pooled_flat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sample[k] = data_in[k*DATA_BIT +: DATA_BIT];
            hmax[k]   = (sample[k] > h_q[k]) ? sample[k] : h_q[k];
            pooled[k] = (lb_q[k][lb_idx] > hmax[k]) ? lb_q[k][lb_idx] : hmax[k];
            if (relu_en && pooled[k][DATA_BIT-1]) begin
                pooled[k] = '0;
            end
            pooled_flat[k*DATA_BIT +: DATA_BIT] = pooled[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                h_q[k] <= '0;
                for (int i = 0; i < LB_DEPTH; i++) begin
                    lb_q[k][i] <= '0;
                end
            end
        end else begin
            valid_out_q  <= win_done;
            frame_done_q <= win_done & col_last & row_last;
            if (win_done) begin
                data_out_q <= pooled_flat;
            end

            if (frame_restart) begin
                col_q <= '0;
                row_q <= '0;
            end else if (valid_in) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!col_q[0]) begin
                        h_q[k] <= sample[k];
                    end else if (!row_q[0]) begin
                        // Top row of the window: park the horizontal max for the row below.
                        lb_q[k][lb_idx] <= hmax[k];
                    end
                end
            end
        end
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_maxpool_relu_nch.sv
// Bench for maxpool_relu_nch: a 4x4 instance and a default 24x24 instance, each checked per cycle
// against a frame-buffer reference that pools 2x2 windows directly from the stored pixels.
module tb_maxpool_relu_nch;

    localparam int DB = 12;
    localparam int NC = 3;
    localparam int DW = DB * NC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic relu_en = 1'b0;
    logic s_restart = 1'b0, s_valid = 1'b0, l_restart = 1'b0, l_valid = 1'b0;
    logic [DW-1:0] s_din = '0, l_din = '0;
    logic s_vout, s_fdone, l_vout, l_fdone;
    logic [DW-1:0] s_dout, l_dout;

    int n_cmp = 0;
    int n_err = 0;
    int n_vout = 0;
    int n_done = 0;
    int pix [0:575][0:2];
    int pidx [2];
    logic [DW-1:0] last_exp [2];

    always #5 clk = ~clk;

    maxpool_relu_nch #(
        .DATA_BIT (DB),
        .NUM_CH   (NC),
        .IN_WIDTH (4),
        .IN_HEIGHT(4),
        .COL_BIT  (2),
        .ROW_BIT  (2)
    ) dut_s (
        .clk          (clk),
        .rst          (rst),
        .relu_en      (relu_en),
        .frame_restart(s_restart),
        .valid_in     (s_valid),
        .data_in      (s_din),
        .valid_out    (s_vout),
        .data_out     (s_dout),
        .frame_done   (s_fdone)
    );

    maxpool_relu_nch dut_l (
        .clk          (clk),
        .rst          (rst),
        .relu_en      (relu_en),
        .frame_restart(l_restart),
        .valid_in     (l_valid),
        .data_in      (l_din),
        .valid_out    (l_vout),
        .data_out     (l_dout),
        .frame_done   (l_fdone)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive a beat on the selected instance (sel=1: 24x24), advance the reference,
    // then check that instance's outputs 1 ns after the edge.
    task automatic cyc(input bit sel, input bit v, input bit rs, input int a0, input int a1,
                       input int a2);
        int w, r, c, m, val;
        int a [3];
        bit nv, nd, ovo, ofd;
        logic [DW-1:0] ed, din, od;
        a[0] = a0; a[1] = a1; a[2] = a2;
        w  = sel ? 24 : 4;
        nv = 1'b0;
        nd = 1'b0;
        ed = last_exp[sel];
        for (int k = 0; k < NC; k++) din[k*DB +: DB] = 12'(a[k]);
        s_valid   = sel ? 1'b0 : v;
        s_restart = sel ? 1'b0 : rs;
        l_valid   = sel ? v : 1'b0;
        l_restart = sel ? rs : 1'b0;
        if (sel) l_din = din; else s_din = din;

        if (rs) begin
            pidx[sel] = 0;
        end else if (v) begin
            for (int k = 0; k < NC; k++) pix[pidx[sel]][k] = a[k];
            r = pidx[sel] / w;
            c = pidx[sel] % w;
            if (r % 2 == 1 && c % 2 == 1) begin
                nv = 1'b1;
                nd = (pidx[sel] == w * w - 1);
                for (int k = 0; k < NC; k++) begin
                    m = pix[pidx[sel]][k];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            val = pix[(r - dr) * w + c - dc][k];
                            if (val > m) m = val;
                        end
                    if (relu_en && m < 0) m = 0;
                    ed[k*DB +: DB] = 12'(m);
                end
            end
            pidx[sel] = (pidx[sel] + 1) % (w * w);
        end

        @(posedge clk);
        #1;
        ovo = sel ? l_vout : s_vout;
        ofd = sel ? l_fdone : s_fdone;
        od  = sel ? l_dout : s_dout;
        if (ovo) n_vout++;
        if (ofd) n_done++;
        chk(sel ? "l_valid_out" : "s_valid_out", DW'(ovo), DW'(nv));
        chk(sel ? "l_data_out" : "s_data_out", od, ed);
        chk(sel ? "l_frame_done" : "s_frame_done", DW'(ofd), DW'(nd));
        last_exp[sel] = ed;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int val;
        pidx[0] = 0; pidx[1] = 0;
        last_exp[0] = '0; last_exp[1] = '0;

        // Reset state
        #12;
        chk("rst_s_valid_out", DW'(s_vout), '0);
        chk("rst_s_data_out", s_dout, '0);
        chk("rst_s_frame_done", DW'(s_fdone), '0);
        chk("rst_l_valid_out", DW'(l_vout), '0);
        chk("rst_l_data_out", l_dout, '0);
        chk("rst_l_frame_done", DW'(l_fdone), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp 0..15 with ReLU: 5, 7, 13, 15 at beats 6, 8, 14, 16
        relu_en = 1'b1;
        n_done = 0;
        for (int p = 0; p < 16; p++) cyc(0, 1, 0, p, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ramp_frame_done_count", DW'(n_done), DW'(1));

        // Negated ramp without, then with, ReLU
        relu_en = 1'b0;
        for (int p = 0; p < 16; p++) cyc(0, 1, 0, -p, -p, -p);
        relu_en = 1'b1;
        for (int p = 0; p < 16; p++) cyc(0, 1, 0, -p, -p, -p);
        cyc(0, 0, 0, 0, 0, 0);

        // Three distinct channels with random valid gaps
        relu_en = 1'b0;
        n_vout = 0;
        for (int p = 0; p < 16; p++) begin
            cyc(0, 1, 0, p - 20, 2 * p - 20, 3 * p - 20);
            repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("gap_valid_count", DW'(n_vout), DW'(4));

        // Restart mid-frame; restart beat carries valid data that must be dropped
        relu_en = 1'b1;
        for (int p = 0; p < 6; p++) cyc(0, 1, 0, 900 + p, 900, 900);
        cyc(0, 1, 1, 1500, 1500, 1500);
        n_vout = 0;
        for (int p = 0; p < 16; p++) cyc(0, 1, 0, p, p, p);
        cyc(0, 0, 0, 0, 0, 0);
        chk("restart_valid_count", DW'(n_vout), DW'(4));

        // Asynchronous reset mid-cycle after 10 beats
        for (int p = 0; p < 10; p++) cyc(0, 1, 0, p + 30, p, p);
        s_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid_out", DW'(s_vout), '0);
        chk("async_rst_data_out", s_dout, '0);
        chk("async_rst_frame_done", DW'(s_fdone), '0);
        #2;
        rst = 1'b0;
        pidx[0] = 0; pidx[1] = 0;
        last_exp[0] = '0; last_exp[1] = '0;
        @(posedge clk);
        #1;
        n_vout = 0;
        for (int p = 0; p < 16; p++) cyc(0, 1, 0, p, 15 - p, p - 8);
        cyc(0, 0, 0, 0, 0, 0);
        chk("post_rst_valid_count", DW'(n_vout), DW'(4));

        // Default geometry: two back-to-back frames with extreme values
        n_vout = 0;
        n_done = 0;
        for (int f = 0; f < 2; f++) begin
            relu_en = f[0];
            for (int p = 0; p < 576; p++) begin
                int v3 [3];
                for (int k = 0; k < NC; k++) begin
                    val = int'($urandom_range(0, 4095)) - 2048;
                    if ((p + k) % 7 == 0) val = -2048;
                    if ((p + k) % 13 == 0) val = 2047;
                    if (f == 0 && (p == 0 || p == 1 || p == 24 || p == 25)) val = -2048;
                    v3[k] = val;
                end
                cyc(1, 1, 0, v3[0], v3[1], v3[2]);
            end
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("big_valid_count", DW'(n_vout), DW'(288));
        chk("big_frame_done_count", DW'(n_done), DW'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
